// File: rtl/param_data_stack_if.sv
// param_data_stack_if
//   Bundles the op strobe from the instruction decoder and the stack
//   observation outputs that feed the ALU and debug ports.
//
//   master : op source (decoder / testbench). Drives OP_VALID, OP, PUSH_DATA.
//   slave  : the stack. Drives POP_DATA, POP_VALID, STACK_TOP_ITEM,
//            STACK_NEXT_ITEM, STACK_ITEM_COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW.
//
//   DATA_WIDTH and COUNT_WIDTH must match the stack instance they connect to.
interface param_data_stack_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
);

  logic                   OP_VALID;
  logic [2:0]             OP;
  logic [DATA_WIDTH-1:0]  PUSH_DATA;

  logic [DATA_WIDTH-1:0]  POP_DATA;
  logic                   POP_VALID;
  logic [DATA_WIDTH-1:0]  STACK_TOP_ITEM;
  logic [DATA_WIDTH-1:0]  STACK_NEXT_ITEM;
  logic [COUNT_WIDTH-1:0] STACK_ITEM_COUNT;
  logic                   FULL;
  logic                   EMPTY;
  logic                   OVERFLOW;
  logic                   UNDERFLOW;

  modport master (
    output OP_VALID, OP, PUSH_DATA,
    input  POP_DATA, POP_VALID, STACK_TOP_ITEM, STACK_NEXT_ITEM,
           STACK_ITEM_COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  OP_VALID, OP, PUSH_DATA,
    output POP_DATA, POP_VALID, STACK_TOP_ITEM, STACK_NEXT_ITEM,
           STACK_ITEM_COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/param_data_stack.sv
// param_data_stack
//   Parametrised data stack for the stack processor core. One op per cycle,
//   every op completes in a single cycle, all outputs come straight from flops.
//
//   Ports:
//     CLK  - system clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - param_data_stack_if.slave
//            in : OP_VALID, OP[2:0], PUSH_DATA
//            out: POP_DATA, POP_VALID, STACK_TOP_ITEM, STACK_NEXT_ITEM,
//                 STACK_ITEM_COUNT, FULL, EMPTY, OVERFLOW, UNDERFLOW
//
//   Ops: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 REPLACE, 7 CLEAR
//
//   Storage: the top two items live in dedicated registers so the ALU sees
//   them without an array read. Items 3..DEPTH live in a DEPTH-2 entry array;
//   with count c, the third item sits at mem[c-3] and a push spills the old
//   second item into mem[c-2]. The top/next registers are kept at zero
//   whenever they do not hold a live item, so stale array or register
//   contents never reach the outputs.
module param_data_stack #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  param_data_stack_if.slave  bus
);

  localparam int CNT_W     = $clog2(DEPTH + 1);
  // DEPTH == 2 needs no spill array; keep a single dummy entry so the
  // declaration stays legal. It is never written in that configuration.
  localparam int MEM_DEPTH = (DEPTH > 2) ? DEPTH - 2 : 1;
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INC   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_DUP     = 3'd3,
    OP_SWAP    = 3'd4,
    OP_OVER    = 3'd5,
    OP_REPLACE = 3'd6,
    OP_CLEAR   = 3'd7
  } op_e;

  op_e op;
  assign op = op_e'(bus.OP);

  logic [DATA_WIDTH-1:0] top_q, top_d;
  logic [DATA_WIDTH-1:0] next_q, next_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [IDX_W-1:0]      mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic has_one, has_two, has_three, is_full;

  assign has_one   = (count_q != '0);
  assign has_two   = (count_q >= CNT_TWO);
  assign has_three = (count_q >= CNT_THREE);
  assign is_full   = (count_q == CNT_FULL);

  // Spill slot for the current second item, and the slot holding the third.
  // Both addresses are only used when the matching has_two/has_three guard
  // holds, so the wrap at small counts is harmless.
  assign mem_waddr = IDX_W'(count_q - CNT_TWO);
  assign mem_raddr = IDX_W'(count_q - CNT_THREE);
  assign mem_rdata = mem_q[mem_raddr];

  always_comb begin
    top_d       = top_q;
    next_d      = next_q;
    pop_data_d  = pop_data_q;
    count_d     = count_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;

    if (bus.OP_VALID) begin
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = has_two;
            next_d  = top_q;
            top_d   = bus.PUSH_DATA;
            count_d = count_q + CNT_INC;
          end
        end

        OP_POP: begin
          if (!has_one) begin
            underflow_d = 1'b1;
          end else begin
            pop_data_d  = top_q;
            pop_valid_d = 1'b1;
            top_d       = next_q;
            next_d      = has_three ? mem_rdata : '0;
            count_d     = count_q - CNT_INC;
          end
        end

        // Underflow is tested before overflow, so DUP on an empty stack
        // always reports underflow.
        OP_DUP: begin
          if (!has_one) begin
            underflow_d = 1'b1;
          end else if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = has_two;
            next_d  = top_q;
            count_d = count_q + CNT_INC;
          end
        end

        OP_SWAP: begin
          if (!has_two) begin
            underflow_d = 1'b1;
          end else begin
            top_d  = next_q;
            next_d = top_q;
          end
        end

        // OVER copies the second item, so like SWAP it needs two items;
        // fewer is treated as underflow.
        OP_OVER: begin
          if (!has_two) begin
            underflow_d = 1'b1;
          end else if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            top_d   = next_q;
            next_d  = top_q;
            count_d = count_q + CNT_INC;
          end
        end

        OP_REPLACE: begin
          if (!has_one) begin
            underflow_d = 1'b1;
          end else begin
            top_d = bus.PUSH_DATA;
          end
        end

        OP_CLEAR: begin
          top_d       = '0;
          next_d      = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end

        default: ;
      endcase
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      top_q       <= '0;
      next_q      <= '0;
      pop_data_q  <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      top_q       <= top_d;
      next_q      <= next_d;
      pop_data_q  <= pop_data_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  // The spill array is not reset; everything at or above count is don't-care.
  // Every op that writes it also moves next_q into it, hence the fixed data.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem_q[mem_waddr] <= next_q;
    end
  end

  assign bus.POP_DATA         = pop_data_q;
  assign bus.POP_VALID        = pop_valid_q;
  assign bus.STACK_TOP_ITEM   = top_q;
  assign bus.STACK_NEXT_ITEM  = next_q;
  assign bus.STACK_ITEM_COUNT = COUNT_WIDTH'(count_q);
  assign bus.FULL             = full_q;
  assign bus.EMPTY            = empty_q;
  assign bus.OVERFLOW         = overflow_q;
  assign bus.UNDERFLOW        = underflow_q;

endmodule

// File: tb/tb_param_data_stack.sv
// Testbench for param_data_stack. Two instances: A (32-bit x 4) and
// B (8-bit x 2, 4-bit count). A reference model keeps each stack as a
// top-first list; every driven op pushes the model's predicted post-op
// state onto a per-instance queue, which is popped and compared once the
// DUT has taken the edge.
module tb_param_data_stack;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_REPLACE = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  typedef struct packed {
    logic [31:0] pop_data;
    logic        pop_valid;
    logic [31:0] top;
    logic [31:0] next;
    logic [31:0] count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } snap_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  always #5 clk = ~clk;

  param_data_stack_if #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) if_a ();
  param_data_stack_if #(.DATA_WIDTH(8),  .COUNT_WIDTH(4))  if_b ();

  param_data_stack #(.DATA_WIDTH(32), .DEPTH(4), .COUNT_WIDTH(32)) u_dut_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (if_a.slave)
  );

  param_data_stack #(.DATA_WIDTH(8), .DEPTH(2), .COUNT_WIDTH(4)) u_dut_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (if_b.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, index 0 = instance A, 1 = instance B.
  logic [31:0] m_items [2][16];
  int          m_cnt   [2];
  logic [31:0] m_pop   [2];
  logic        m_pv    [2];
  logic        m_ovf   [2];
  logic        m_unf   [2];

  snap_t exp_q_a [$];
  snap_t exp_q_b [$];

  task automatic m_push(input int s, input logic [31:0] val);
    for (int i = 15; i > 0; i--) m_items[s][i] = m_items[s][i-1];
    m_items[s][0] = val;
    m_cnt[s]++;
  endtask

  task automatic m_drop(input int s);
    for (int i = 0; i < 15; i++) m_items[s][i] = m_items[s][i+1];
    m_cnt[s]--;
  endtask

  task automatic model_step(input int s, input logic rst, input logic v,
                            input logic [2:0] op, input logic [31:0] d_in);
    logic [31:0] d, t;
    int depth;
    depth = (s == 0) ? 4 : 2;
    d     = (s == 0) ? d_in : (d_in & 32'h0000_00FF);
    if (rst) begin
      m_cnt[s] = 0; m_pop[s] = '0; m_pv[s] = 1'b0;
      m_ovf[s] = 1'b0; m_unf[s] = 1'b0;
    end else begin
      m_pv[s] = 1'b0;
      if (v) begin
        case (op)
          OP_PUSH: if (m_cnt[s] == depth) m_ovf[s] = 1'b1; else m_push(s, d);
          OP_POP: begin
            if (m_cnt[s] == 0) m_unf[s] = 1'b1;
            else begin
              m_pop[s] = m_items[s][0];
              m_pv[s]  = 1'b1;
              m_drop(s);
            end
          end
          OP_DUP: begin
            if (m_cnt[s] == 0) m_unf[s] = 1'b1;
            else if (m_cnt[s] == depth) m_ovf[s] = 1'b1;
            else m_push(s, m_items[s][0]);
          end
          OP_SWAP: begin
            if (m_cnt[s] < 2) m_unf[s] = 1'b1;
            else begin
              t = m_items[s][0];
              m_items[s][0] = m_items[s][1];
              m_items[s][1] = t;
            end
          end
          OP_OVER: begin
            if (m_cnt[s] < 2) m_unf[s] = 1'b1;
            else if (m_cnt[s] == depth) m_ovf[s] = 1'b1;
            else m_push(s, m_items[s][1]);
          end
          OP_REPLACE: if (m_cnt[s] == 0) m_unf[s] = 1'b1; else m_items[s][0] = d;
          OP_CLEAR: begin
            m_cnt[s] = 0; m_ovf[s] = 1'b0; m_unf[s] = 1'b0;
          end
          default: ;
        endcase
      end
    end
  endtask

  function automatic snap_t expected(input int s);
    snap_t e;
    int depth;
    depth       = (s == 0) ? 4 : 2;
    e.pop_data  = m_pop[s];
    e.pop_valid = m_pv[s];
    e.top       = (m_cnt[s] >= 1) ? m_items[s][0] : 32'd0;
    e.next      = (m_cnt[s] >= 2) ? m_items[s][1] : 32'd0;
    e.count     = 32'(m_cnt[s]);
    e.full      = (m_cnt[s] == depth);
    e.empty     = (m_cnt[s] == 0);
    e.ovf       = m_ovf[s];
    e.unf       = m_unf[s];
    return e;
  endfunction

  function automatic snap_t sample(input int s);
    snap_t r;
    if (s == 0) begin
      r.pop_data  = if_a.POP_DATA;
      r.pop_valid = if_a.POP_VALID;
      r.top       = if_a.STACK_TOP_ITEM;
      r.next      = if_a.STACK_NEXT_ITEM;
      r.count     = if_a.STACK_ITEM_COUNT;
      r.full      = if_a.FULL;
      r.empty     = if_a.EMPTY;
      r.ovf       = if_a.OVERFLOW;
      r.unf       = if_a.UNDERFLOW;
    end else begin
      r.pop_data  = 32'(if_b.POP_DATA);
      r.pop_valid = if_b.POP_VALID;
      r.top       = 32'(if_b.STACK_TOP_ITEM);
      r.next      = 32'(if_b.STACK_NEXT_ITEM);
      r.count     = 32'(if_b.STACK_ITEM_COUNT);
      r.full      = if_b.FULL;
      r.empty     = if_b.EMPTY;
      r.ovf       = if_b.OVERFLOW;
      r.unf       = if_b.UNDERFLOW;
    end
    return r;
  endfunction

  // Drives one op into instance s (the other instance idles with a NOP),
  // records the predicted result, then waits until just after the edge.
  task automatic drive(input int s, input logic rst, input logic v,
                       input logic [2:0] op, input logic [31:0] d);
    if (s == 0) begin
      rst_a = rst; if_a.OP_VALID = v; if_a.OP = op; if_a.PUSH_DATA = d;
      rst_b = 1'b0; if_b.OP_VALID = 1'b0;
      model_step(0, rst, v, op, d);
      model_step(1, 1'b0, 1'b0, OP_NOP, 32'd0);
      exp_q_a.push_back(expected(0));
    end else begin
      rst_b = rst; if_b.OP_VALID = v; if_b.OP = op; if_b.PUSH_DATA = d[7:0];
      rst_a = 1'b0; if_a.OP_VALID = 1'b0;
      model_step(1, rst, v, op, d);
      model_step(0, 1'b0, 1'b0, OP_NOP, 32'd0);
      exp_q_b.push_back(expected(1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    snap_t exp_a, exp_b, obs_a, obs_b, zero;
    zero = '0;
    zero.empty = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.OP_VALID = 1'b0; if_a.OP = OP_NOP; if_a.PUSH_DATA = '0;
    if_b.OP_VALID = 1'b0; if_b.OP = OP_NOP; if_b.PUSH_DATA = '0;
    for (int c = 0; c < 2; c++) begin
      model_step(0, 1'b1, 1'b0, OP_NOP, 32'd0);
      model_step(1, 1'b1, 1'b0, OP_NOP, 32'd0);
      exp_q_a.push_back(expected(0));
      exp_q_b.push_back(expected(1));
      @(posedge clk);
      #1;
      exp_a = exp_q_a.pop_front(); obs_a = sample(0);
      exp_b = exp_q_b.pop_front(); obs_b = sample(1);
      n_tests++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL reset_a cyc%0d got=%p want=%p", c, obs_a, exp_a);
      end
      n_tests++;
      if (obs_b !== exp_b) begin
        n_fail++; $display("FAIL reset_b cyc%0d got=%p want=%p", c, obs_b, exp_b);
      end
    end
    n_tests++;
    if (obs_a !== zero) begin
      n_fail++; $display("FAIL reset_a_zero got=%p want=%p", obs_a, zero);
    end
  endtask

  task automatic test_fill;
    logic [31:0] dat [3] = '{32'd5, 32'd7, 32'd9};
    snap_t exp, obs;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b1, OP_PUSH, dat[i]);
      exp = exp_q_a.pop_front(); obs = sample(0);
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL fill step%0d got=%p want=%p", i, obs, exp);
      end
    end
    n_tests++;
    if (obs.top !== 32'd9 || obs.next !== 32'd7 || obs.count !== 32'd3 || obs.full !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_final got top=%0d next=%0d count=%0d full=%0b want 9 7 3 0",
               obs.top, obs.next, obs.count, obs.full);
    end
  endtask

  task automatic test_arith;
    logic [2:0]  ops [8] = '{OP_CLEAR, OP_PUSH, OP_PUSH, OP_SWAP, OP_OVER, OP_POP, OP_REPLACE, OP_NOP};
    logic [31:0] dat [8] = '{32'd0, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'h2A, 32'd0};
    snap_t seen [8];
    snap_t exp;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b1, ops[i], dat[i]);
      exp = exp_q_a.pop_front(); seen[i] = sample(0);
      n_tests++;
      if (seen[i] !== exp) begin
        n_fail++; $display("FAIL arith step%0d got=%p want=%p", i, seen[i], exp);
      end
    end
    n_tests++;
    if (seen[3].top !== 32'd3 || seen[3].next !== 32'd4) begin
      n_fail++; $display("FAIL arith_swap got top=%0d next=%0d want 3 4", seen[3].top, seen[3].next);
    end
    n_tests++;
    if (seen[4].top !== 32'd4 || seen[4].next !== 32'd3 || seen[4].count !== 32'd3) begin
      n_fail++;
      $display("FAIL arith_over got top=%0d next=%0d count=%0d want 4 3 3",
               seen[4].top, seen[4].next, seen[4].count);
    end
    n_tests++;
    if (seen[5].pop_data !== 32'd4 || seen[5].pop_valid !== 1'b1 || seen[5].top !== 32'd3
        || seen[6].pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arith_pop got pop_data=%0d pv=%0b top=%0d pv_next=%0b want 4 1 3 0",
               seen[5].pop_data, seen[5].pop_valid, seen[5].top, seen[6].pop_valid);
    end
    n_tests++;
    if (seen[6].top !== 32'h2A || seen[6].count !== 32'd2) begin
      n_fail++; $display("FAIL arith_replace got top=%0h count=%0d want 2a 2", seen[6].top, seen[6].count);
    end
  endtask

  task automatic test_overflow;
    logic [2:0]  ops [8] = '{OP_CLEAR, OP_PUSH, OP_PUSH, OP_PUSH, OP_PUSH, OP_PUSH, OP_DUP, OP_POP};
    logic [31:0] dat [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0};
    snap_t seen [8];
    snap_t exp;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b1, ops[i], dat[i]);
      exp = exp_q_a.pop_front(); seen[i] = sample(0);
      n_tests++;
      if (seen[i] !== exp) begin
        n_fail++; $display("FAIL overflow step%0d got=%p want=%p", i, seen[i], exp);
      end
    end
    n_tests++;
    if (seen[4].full !== 1'b1 || seen[4].ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full got full=%0b ovf=%0b want 1 0", seen[4].full, seen[4].ovf);
    end
    n_tests++;
    if (seen[5].ovf !== 1'b1 || seen[5].top !== 32'd4 || seen[5].count !== 32'd4) begin
      n_fail++;
      $display("FAIL ovf_push got ovf=%0b top=%0d count=%0d want 1 4 4", seen[5].ovf, seen[5].top, seen[5].count);
    end
    n_tests++;
    if (seen[6].count !== 32'd4 || seen[6].top !== 32'd4) begin
      n_fail++; $display("FAIL ovf_dup got count=%0d top=%0d want 4 4", seen[6].count, seen[6].top);
    end
    n_tests++;
    if (seen[7].pop_data !== 32'd4 || seen[7].count !== 32'd3 || seen[7].ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pop got pop_data=%0d count=%0d ovf=%0b want 4 3 1",
               seen[7].pop_data, seen[7].count, seen[7].ovf);
    end
  endtask

  task automatic test_underflow;
    logic [2:0]  ops [5] = '{OP_CLEAR, OP_POP, OP_PUSH, OP_SWAP, OP_CLEAR};
    logic [31:0] dat [5] = '{32'd0, 32'd0, 32'd8, 32'd0, 32'd0};
    snap_t seen [5];
    snap_t exp;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 1'b1, ops[i], dat[i]);
      exp = exp_q_a.pop_front(); seen[i] = sample(0);
      n_tests++;
      if (seen[i] !== exp) begin
        n_fail++; $display("FAIL underflow step%0d got=%p want=%p", i, seen[i], exp);
      end
    end
    n_tests++;
    if (seen[1].unf !== 1'b1 || seen[1].pop_valid !== 1'b0 || seen[1].pop_data !== 32'd4) begin
      n_fail++;
      $display("FAIL unf_pop got unf=%0b pv=%0b pop_data=%0d want 1 0 4",
               seen[1].unf, seen[1].pop_valid, seen[1].pop_data);
    end
    n_tests++;
    if (seen[3].unf !== 1'b1 || seen[3].top !== 32'd8 || seen[3].count !== 32'd1) begin
      n_fail++;
      $display("FAIL unf_swap got unf=%0b top=%0d count=%0d want 1 8 1", seen[3].unf, seen[3].top, seen[3].count);
    end
    n_tests++;
    if (seen[4].count !== 32'd0 || seen[4].unf !== 1'b0 || seen[4].ovf !== 1'b0 || seen[4].empty !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_clear got count=%0d unf=%0b ovf=%0b empty=%0b want 0 0 0 1",
               seen[4].count, seen[4].unf, seen[4].ovf, seen[4].empty);
    end
  endtask

  task automatic test_reset_midstream;
    logic        rsts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] dat  [5] = '{32'd10, 32'd11, 32'd12, 32'd6, 32'd6};
    snap_t seen [5];
    snap_t exp;
    for (int i = 0; i < 5; i++) begin
      drive(0, rsts[i], 1'b1, OP_PUSH, dat[i]);
      exp = exp_q_a.pop_front(); seen[i] = sample(0);
      n_tests++;
      if (seen[i] !== exp) begin
        n_fail++; $display("FAIL rst_mid step%0d got=%p want=%p", i, seen[i], exp);
      end
    end
    n_tests++;
    if (seen[3].count !== 32'd0 || seen[3].top !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_clear got count=%0d top=%0d want 0 0", seen[3].count, seen[3].top);
    end
    n_tests++;
    if (seen[4].top !== 32'd6 || seen[4].next !== 32'd0 || seen[4].count !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_mid_push got top=%0d next=%0d count=%0d want 6 0 1", seen[4].top, seen[4].next, seen[4].count);
    end
  endtask

  task automatic test_param;
    logic        rsts [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  ops  [4] = '{OP_NOP, OP_PUSH, OP_PUSH, OP_OVER};
    logic [31:0] dat  [4] = '{32'd0, 32'hFF, 32'h01, 32'd0};
    snap_t seen [4];
    snap_t exp;
    for (int i = 0; i < 4; i++) begin
      drive(1, rsts[i], 1'b1, ops[i], dat[i]);
      exp = exp_q_b.pop_front(); seen[i] = sample(1);
      n_tests++;
      if (seen[i] !== exp) begin
        n_fail++; $display("FAIL param step%0d got=%p want=%p", i, seen[i], exp);
      end
    end
    n_tests++;
    if (seen[2].full !== 1'b1 || seen[2].top !== 32'h01 || seen[2].next !== 32'hFF || seen[2].count !== 32'd2) begin
      n_fail++;
      $display("FAIL param_full got full=%0b top=%0h next=%0h count=%0d want 1 01 ff 2",
               seen[2].full, seen[2].top, seen[2].next, seen[2].count);
    end
    n_tests++;
    if (seen[3].ovf !== 1'b1 || seen[3].count !== 32'd2) begin
      n_fail++; $display("FAIL param_over got ovf=%0b count=%0d want 1 2", seen[3].ovf, seen[3].count);
    end
  endtask

  task automatic test_random(input int s, input int n);
    snap_t exp, obs;
    logic rst, v;
    logic [2:0] op;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 9) != 0);
      op  = 3'($urandom_range(0, 7));
      d   = $urandom;
      drive(s, rst, v, op, d);
      if (s == 0) exp = exp_q_a.pop_front();
      else        exp = exp_q_b.pop_front();
      obs = sample(s);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random%0d op%0d rst=%0b v=%0b op=%0d got=%p want=%p", s, i, rst, v, op, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_arith();
    test_overflow();
    test_underflow();
    test_reset_midstream();
    test_param();
    test_random(1, 1000);
    test_random(0, 600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
